// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: debounce FSM state encoding and a width helper.
package btn_pkg;

  typedef enum logic [2:0] {
    RELEASED  = 3'd0,
    PRESS_DEB = 3'd1,
    PRESSED   = 3'd2,
    HELD      = 3'd3,
    REL_DEB   = 3'd4
  } btn_state_t;

  // Bits needed to index 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running prescaler: tick is high for one CLK every PRESCALE cycles (every cycle when PRESCALE = 1).
// Tick is combinational from the count register; there is no backpressure, the tick is never held off.
module sample_tick_gen
  import btn_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = clog2_min1(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: 2-flop sync, tick-sampled debounce FSM, registered level/press/release/hold outputs.
// Pulses appear one CLK after the accepting tick; no backpressure, the consumer samples them directly.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int PRESCALE       = 50000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int HOLD_TICKS     = 200,
  parameter bit IN_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic Btn_Raw,
  output logic Btn_Level,
  output logic Btn_Press,
  output logic Btn_Release,
  output logic Btn_Hold
);

  localparam int DW = clog2_min1(DEBOUNCE_TICKS + 1);
  localparam int HW = clog2_min1(HOLD_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);
  localparam bit DEB_IMMEDIATE = (DEBOUNCE_TICKS == 1);

  logic          sync1, sync2, pressed_s, tick;
  btn_state_t    state, state_nxt, origin, origin_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt, deb_inc;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt, hold_inc;
  logic          level_nxt, press_nxt, release_nxt, hold_nxt;
  logic          do_press, do_release;

  sample_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .tick(tick)
  );

  // Reset loads the released pin level so no phantom edge follows reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= IN_ACTIVE_LOW;
      sync2 <= IN_ACTIVE_LOW;
    end else begin
      sync1 <= Btn_Raw;
      sync2 <= sync1;
    end
  end

  assign pressed_s = sync2 ^ IN_ACTIVE_LOW;
  assign deb_inc   = deb_cnt + DEB_ONE;
  assign hold_inc  = hold_cnt + HW'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= RELEASED;
      origin      <= PRESSED;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      Btn_Level   <= 1'b0;
      Btn_Press   <= 1'b0;
      Btn_Release <= 1'b0;
      Btn_Hold    <= 1'b0;
    end else begin
      state       <= state_nxt;
      origin      <= origin_nxt;
      deb_cnt     <= deb_nxt;
      hold_cnt    <= hold_cnt_nxt;
      Btn_Level   <= level_nxt;
      Btn_Press   <= press_nxt;
      Btn_Release <= release_nxt;
      Btn_Hold    <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    origin_nxt   = origin;
    deb_nxt      = deb_cnt;
    hold_cnt_nxt = hold_cnt;
    level_nxt    = Btn_Level;
    hold_nxt     = Btn_Hold;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    do_press     = 1'b0;
    do_release   = 1'b0;

    if (tick) begin
      unique case (state)
        RELEASED: begin
          if (pressed_s) begin
            deb_nxt = DEB_ONE;
            if (DEB_IMMEDIATE) do_press = 1'b1;
            else               state_nxt = PRESS_DEB;
          end
        end
        PRESS_DEB: begin
          if (pressed_s) begin
            if (deb_inc == DEB_LAST) do_press = 1'b1;
            else                     deb_nxt  = deb_inc;
          end else begin
            deb_nxt   = '0;
            state_nxt = RELEASED;
          end
        end
        PRESSED, HELD: begin
          if (!pressed_s) begin
            // hold_cnt is left alone so a bounce back resumes the same hold timing
            origin_nxt = state;
            if (DEB_IMMEDIATE) begin
              do_release = 1'b1;
            end else begin
              deb_nxt   = DEB_ONE;
              state_nxt = REL_DEB;
            end
          end else if (state == PRESSED && hold_cnt != HOLD_LAST) begin
            hold_cnt_nxt = hold_inc;
            if (hold_inc == HOLD_LAST) begin
              state_nxt = HELD;
              hold_nxt  = 1'b1;
            end
          end
        end
        REL_DEB: begin
          if (!pressed_s) begin
            if (deb_inc == DEB_LAST) do_release = 1'b1;
            else                     deb_nxt    = deb_inc;
          end else begin
            deb_nxt   = '0;
            state_nxt = origin;
          end
        end
        default: begin
          state_nxt = RELEASED;
          deb_nxt   = '0;
        end
      endcase
    end

    if (do_press) begin
      state_nxt    = PRESSED;
      deb_nxt      = '0;
      hold_cnt_nxt = '0;
      level_nxt    = 1'b1;
      press_nxt    = 1'b1;
    end
    if (do_release) begin
      state_nxt   = RELEASED;
      deb_nxt     = '0;
      level_nxt   = 1'b0;
      hold_nxt    = 1'b0;
      release_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Randomised + directed bench: a sample-level reference model predicts pulses into a scoreboard queue
// and the expected level/hold each cycle; a negedge monitor compares the DUT against it.
module tb_btn_debounce_pulse;

  localparam int P   = 4;
  localparam int D   = 3;
  localparam int H   = 5;
  localparam bit IAL = 1'b1;
  localparam int KIND_PRESS = 1;
  localparam int KIND_REL   = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Btn_Raw = 1'b1;
  logic Btn_Level, Btn_Press, Btn_Release, Btn_Hold;
  logic raw2 = 1'b1;
  logic b_level, b_press, b_rel, b_hold;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  btn_debounce_pulse #(
    .PRESCALE(P), .DEBOUNCE_TICKS(D), .HOLD_TICKS(H), .IN_ACTIVE_LOW(IAL)
  ) dut (
    .CLK(CLK), .RST(RST), .Btn_Raw(Btn_Raw),
    .Btn_Level(Btn_Level), .Btn_Press(Btn_Press), .Btn_Release(Btn_Release), .Btn_Hold(Btn_Hold)
  );

  btn_debounce_pulse #(
    .PRESCALE(1), .DEBOUNCE_TICKS(1), .HOLD_TICKS(5), .IN_ACTIVE_LOW(1'b1)
  ) dut_fast (
    .CLK(CLK), .RST(RST), .Btn_Raw(raw2),
    .Btn_Level(b_level), .Btn_Press(b_press), .Btn_Release(b_rel), .Btn_Hold(b_hold)
  );

  // Posedge k happens at time 10k+5; both edges of cycle k map to k.
  function automatic longint cyc_now();
    return (longint'($time) - 5) / 10;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_now());
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     kind;
    longint cyc;
  } ev_t;

  ev_t    exp_q[$];
  bit     pin_delay[$];
  longint ph;
  int     run, m_hold_ticks;
  bit     m_level, m_held;

  always @(posedge CLK or negedge RST) begin
    bit  samp, want;
    ev_t e;
    if (!RST) begin
      pin_delay.delete();
      pin_delay.push_back(IAL);
      pin_delay.push_back(IAL);
      ph = 0; run = 0; m_hold_ticks = 0;
      m_level = 1'b0; m_held = 1'b0;
      exp_q.delete();
    end else begin
      samp = pin_delay.pop_front();
      pin_delay.push_back(Btn_Raw);
      if ((ph % P) == P - 1) begin
        want = samp ^ IAL;
        if (want != m_level) begin
          run++;
          if (run == D) begin
            m_level = want;
            run = 0;
            e.kind = want ? KIND_PRESS : KIND_REL;
            e.cyc  = cyc_now();
            exp_q.push_back(e);
            if (want) m_hold_ticks = 0;
            else      m_held = 1'b0;
          end
        end else begin
          // a tick that ends a release bounce does not advance the hold timer
          if (m_level && run == 0 && m_hold_ticks < H) begin
            m_hold_ticks++;
            if (m_hold_ticks == H) m_held = 1'b1;
          end
          run = 0;
        end
      end
      ph++;
    end
  end

  // ---------------- monitor ----------------
  int     press_cnt = 0, rel_cnt = 0;
  longint last_press = -1000, last_hold_rise = -1000;
  bit     hold_prev = 1'b0, hold_at_rel = 1'b1, level_seen = 1'b0;

  always @(negedge CLK) begin
    ev_t    e;
    longint now;
    now = cyc_now();
    if (!RST) begin
      chk("reset_level", Btn_Level, 0);
      chk("reset_press", Btn_Press, 0);
      chk("reset_release", Btn_Release, 0);
      chk("reset_hold", Btn_Hold, 0);
    end else begin
      chk("level", Btn_Level, m_level);
      chk("hold", Btn_Hold, m_held);
    end
    chk("press_release_overlap", Btn_Press & Btn_Release, 0);
    if (Btn_Press || Btn_Release) begin
      chk("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pulse_kind", Btn_Press ? KIND_PRESS : KIND_REL, e.kind);
        chk("pulse_cycle", now, e.cyc);
      end
      if (Btn_Press) begin press_cnt++; last_press = now; end
      if (Btn_Release) begin rel_cnt++; hold_at_rel = Btn_Hold; end
    end
    if (exp_q.size() > 0) begin
      chk("pulse_not_missed", exp_q[0].cyc >= now, 1);
      if (exp_q[0].cyc < now) void'(exp_q.pop_front());
    end
    if (Btn_Hold && !hold_prev) last_hold_rise = now;
    hold_prev = Btn_Hold;
    if (Btn_Level) level_seen = 1'b1;
  end

  int     b_press_n = 0, b_rel_n = 0;
  longint b_press_cyc = -1, b_rel_cyc = -1;

  always @(negedge CLK) begin
    chk("fast_overlap", b_press & b_rel, 0);
    if (b_press) begin b_press_n++; b_press_cyc = cyc_now(); end
    if (b_rel)   begin b_rel_n++;   b_rel_cyc   = cyc_now(); end
  end

  // ---------------- stimulus ----------------
  initial begin
    longint c0, lat;
    int p0, r0;

    step(3);
    RST = 1'b1;
    step(5);

    // fast instance: one-cycle low pin gives press at +3 and release at +4
    c0 = cyc_now();
    raw2 = 1'b0;
    step(1);
    raw2 = 1'b1;
    step(8);
    chk("fast_press_cycle", b_press_cyc - c0, 3);
    chk("fast_release_cycle", b_rel_cyc - c0, 4);
    chk("fast_press_count", b_press_n, 1);
    chk("fast_release_count", b_rel_n, 1);
    chk("fast_level_idle", b_level, 0);

    // clean press
    p0 = press_cnt;
    c0 = cyc_now();
    Btn_Raw = 1'b0;
    step(40);
    lat = last_press - c0;
    chk("clean_press_count", press_cnt - p0, 1);
    chk("clean_press_latency_11_15", (lat >= 11 && lat <= 15), 1);
    chk("clean_level_high", Btn_Level, 1);
    Btn_Raw = 1'b1;
    step(30);
    chk("clean_level_low", Btn_Level, 0);

    // bounce: toggle every 3 cycles, nothing must be accepted
    p0 = press_cnt; r0 = rel_cnt; level_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Btn_Raw = ~Btn_Raw;
      step(3);
    end
    Btn_Raw = 1'b1;
    step(20);
    chk("bounce_press_count", press_cnt - p0, 0);
    chk("bounce_release_count", rel_cnt - r0, 0);
    chk("bounce_level_seen", level_seen, 0);

    // long press: hold rises 5 ticks after the press pulse
    p0 = press_cnt;
    Btn_Raw = 1'b0;
    step(60);
    chk("long_press_count", press_cnt - p0, 1);
    chk("long_hold_delay", last_hold_rise - last_press, 20);
    chk("long_hold_high", Btn_Hold, 1);

    // release from HELD with a one-tick bounce back to pressed
    r0 = rel_cnt;
    Btn_Raw = 1'b1;
    step(8);
    Btn_Raw = 1'b0;
    step(4);
    chk("glitch_level_kept", Btn_Level, 1);
    chk("glitch_hold_kept", Btn_Hold, 1);
    chk("glitch_no_release", rel_cnt - r0, 0);
    hold_at_rel = 1'b1;
    Btn_Raw = 1'b1;
    step(30);
    chk("held_release_count", rel_cnt - r0, 1);
    chk("hold_low_at_release", hold_at_rel, 0);

    // reset while pressed: fresh press after reset
    Btn_Raw = 1'b0;
    step(20);
    chk("pre_reset_level", Btn_Level, 1);
    RST = 1'b0;
    step(3);
    p0 = press_cnt;
    RST = 1'b1;
    c0 = cyc_now();
    step(20);
    lat = last_press - c0;
    chk("post_reset_press_count", press_cnt - p0, 1);
    chk("post_reset_latency_11_15", (lat >= 11 && lat <= 15), 1);
    Btn_Raw = 1'b1;
    step(30);

    // random pin activity, with one reset in the middle
    for (int k = 0; k < 80; k++) begin
      Btn_Raw = 1'($urandom_range(0, 1));
      step($urandom_range(1, 30));
      if (k == 40) begin
        RST = 1'b0;
        step(2);
        RST = 1'b1;
      end
    end
    Btn_Raw = 1'b1;
    step(40);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_level", Btn_Level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
